hdu_scoreboard: RTL and testbench
=================================

Name: hdu_scoreboard

Overview:
- Parametrised hazard unit for the in-order pipeline; it replaces the single-previous-RD forwarding compare.
- A shift-register scoreboard tracks the destination registers of up to FWD_DEPTH in-flight instructions, from EX through WB.
- For each ID-stage source operand it produces a forwarding select (youngest matching producer wins).
- It raises a load-use stall when the youngest producer's data is not yet available, inserts a bubble, and counts stall cycles.

Parameters:
- REG_ADDRESS_LENGTH, 5, width of register addresses.
- FWD_DEPTH, 3, number of tracked stages after ID (stage 1 = EX, 2 = MEM, 3 = WB).
- LOAD_READY_STAGE, 2, first stage index at which a load result can be forwarded (2..FWD_DEPTH).
- CNT_WIDTH, 16, width of the stall performance counter.

Ports:
- clk  input  1  pipeline clock.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rA  input  REG_ADDRESS_LENGTH  source A address.
- id_rB  input  REG_ADDRESS_LENGTH  source B address.
- id_wr_en  input  1  ID instruction writes a register.
- id_rd  input  REG_ADDRESS_LENGTH  ID destination address.
- id_is_load  input  1  ID instruction is a load.
- hold  input  1  global freeze (memory stall); scoreboard does not shift.
- fwd_sel_rA  output  SEL_W  0 = register file, k = forward from stage k (SEL_W = clog2(FWD_DEPTH+1)).
- fwd_sel_rB  output  SEL_W  same for operand B.
- stall  output  1  freeze IF/ID this cycle; bubble enters EX.
- stall_count  output  CNT_WIDTH  saturating count of stall cycles.

Behaviour:
- State:
  - Entry k (1..FWD_DEPTH) = {v_k, rd_k, ld_k}.
  - Entry k is ready = v_k && (!ld_k || k >= LOAD_READY_STAGE).
- Reset (rst_n low, asynchronous):
  - All v_k = 0, stall_count = 0.
  - Hence fwd_sel_rA = fwd_sel_rB = 0 and stall = 0 while in reset and immediately after it.
- Match for source s:
  - match_k(s) = v_k && rd_k == s && s != 0.
  - Register 0 never matches.
- Forwarding select:
  - fwd_sel_s = the smallest k with match_k(s), else 0.
  - Combinational from current state and ID inputs; zero latency.
- Hazard on source s:
  - The smallest matching k exists and entry k is not ready.
  - Older matches are ignored; the youngest producer always governs.
- stall = id_valid && (hazard(rA) || hazard(rB)).
  - Combinational.
  - Asserted regardless of hold.
  - When id_valid = 0: stall = 0, but fwd_sel is still computed.
- Shift on clock edge when hold = 0:
  - Entry k <= entry k-1 for k >= 2.
  - Entry 1 <= bubble (v = 0) if stall or !id_valid.
  - Otherwise entry 1 <= {id_wr_en && id_rd != 0, id_rd, id_is_load}.
  - Entry FWD_DEPTH retires. The register file is written in that cycle and read-after-write bypassed internally, so the next ID read sees it with select 0.
- hold = 1:
  - All entries keep their values.
  - stall_count does not increment.
  - Outputs continue to reflect the frozen state.
- stall_count:
  - Increments by 1 on each edge with stall && !hold.
  - Saturates at all-ones and does not wrap.
- Load-use timing (defaults):
  - A load followed immediately by a dependent instruction gives exactly 1 stall cycle.
  - The next cycle forwards from stage 2.
- With LOAD_READY_STAGE = 3: the same sequence gives 2 stall cycles, then forwards from stage 3.
- Simultaneous events:
  - rA == rB: both selects are identical.
  - A hazard on one operand stalls the whole instruction, even if the other forwards.
  - ID instruction's own rd == rA: no self-hazard, since it is not yet in the scoreboard.
- Reset mid-operation: all entries are cleared immediately (asynchronous) and no stale forward survives.

Decomposition:
- Shared package holds:
  - REG_ADDRESS_LENGTH default.
  - Stage index constants STG_EX = 1, STG_MEM = 2, STG_WB = 3.
  - FWD_SRC_RF = 0 select encoding.
  - Scoreboard entry struct {valid, rd, is_load}.
- One sub-module: hdu_fwd_pick.
  - Priority match of one source address against all entries.
  - Returns select and hazard.
  - Instantiated twice, for rA and rB.

Test Plan:
1. Reset, then ADD r3 issued, then next ID reads rA = 3 -> fwd_sel_rA = 1, stall = 0. Following cycle, with an unrelated instruction between -> fwd_sel_rA = 2.
2. LOAD r5, then next ID reads rB = 5 -> stall = 1 for one cycle, entry 1 becomes bubble, stall_count = 1. Next cycle -> stall = 0, fwd_sel_rB = 2.
3. ADD r4 then SUB r4 issued back-to-back, then ID reads r4 -> fwd_sel = 1 (SUB, youngest), not 2.
4. Instruction writing r0, then ID reads rA = 0 -> fwd_sel_rA = 0, stall = 0. Also LOAD r7 with hold = 1 for 3 cycles and dependent ID -> stall stays 1, stall_count unchanged, entries frozen. Release hold -> proceeds as in scenario 2.
5. CNT_WIDTH = 2, force 5 consecutive load-use stalls -> stall_count reaches 3 and stays 3.
6. Assert rst_n = 0 mid-sequence with 3 valid entries -> all selects 0 and stall 0 immediately. After release, a dependent ID -> fwd_sel 0.

Source files
------------

// File: rtl/hdu_scoreboard_pkg.sv
// Shared types and constants for the hazard detection unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hdu_scoreboard_pkg;

    // Default register address width of the in-order core.
    localparam int REG_ADDRESS_LENGTH_DEF = 5;

    // Pipeline stage indices as seen from ID (entry k of the scoreboard).
    localparam int STG_EX  = 1;
    localparam int STG_MEM = 2;
    localparam int STG_WB  = 3;

    // Forwarding select value meaning "take the operand from the register file".
    localparam int FWD_SRC_RF = 0;

    // One scoreboard entry: an in-flight producer of a destination register.
    typedef struct packed {
        logic                              valid;
        logic [REG_ADDRESS_LENGTH_DEF-1:0] rd;
        logic                              is_load;
    } sb_entry_t;

endpackage : hdu_scoreboard_pkg

// File: rtl/hdu_fwd_pick.sv
// Priority match of one source operand against all scoreboard entries.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the hazard output feeds the stall decision upstream.
module hdu_fwd_pick
    import hdu_scoreboard_pkg::*;
#(
    parameter int ADDR_W     = REG_ADDRESS_LENGTH_DEF,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = STG_MEM,
    parameter int SEL_W      = 2
) (
    input  logic [ADDR_W-1:0]       src,
    input  logic [DEPTH-1:0]        ent_valid,
    input  logic [DEPTH*ADDR_W-1:0] ent_rd,
    input  logic [DEPTH-1:0]        ent_load,
    output logic [SEL_W-1:0]        sel,
    output logic                    hazard
);

    // Walk from the oldest entry to the youngest so the youngest match is the
    // last one written and therefore wins. Only that producer decides whether
    // its data is available; older matches are overridden entirely.
    always_comb begin
        sel    = SEL_W'(FWD_SRC_RF);
        hazard = 1'b0;
        if (src != '0) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (ent_valid[k-1] && (ent_rd[(k-1)*ADDR_W +: ADDR_W] == src)) begin
                    sel    = SEL_W'(k);
                    // A load only has its data from LOAD_READY onwards.
                    hazard = ent_load[k-1] && (k < LOAD_READY);
                end
            end
        end
    end

endmodule : hdu_fwd_pick

// File: rtl/hdu_scoreboard.sv
// Shift-register scoreboard giving per-operand forwarding selects and load-use stalls.
// Latency: selects and stall are combinational from state and ID inputs; state shifts each edge.
// Backpressure: stall freezes IF/ID and injects a bubble; hold freezes the whole scoreboard.
module hdu_scoreboard
    import hdu_scoreboard_pkg::*;
#(
    parameter int REG_ADDRESS_LENGTH = REG_ADDRESS_LENGTH_DEF,
    parameter int FWD_DEPTH          = 3,
    parameter int LOAD_READY_STAGE   = STG_MEM,
    parameter int CNT_WIDTH          = 16,
    parameter int SEL_W              = $clog2(FWD_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          id_valid,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_rA,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_rB,
    input  logic                          id_wr_en,
    input  logic [REG_ADDRESS_LENGTH-1:0] id_rd,
    input  logic                          id_is_load,
    input  logic                          hold,
    output logic [SEL_W-1:0]              fwd_sel_rA,
    output logic [SEL_W-1:0]              fwd_sel_rB,
    output logic                          stall,
    output logic [CNT_WIDTH-1:0]          stall_count
);

    localparam int AW = REG_ADDRESS_LENGTH;

    // Scoreboard storage; bit/slice k-1 holds stage k (k = 1 is EX).
    logic [FWD_DEPTH-1:0]    sb_valid;
    logic [FWD_DEPTH*AW-1:0] sb_rd;
    logic [FWD_DEPTH-1:0]    sb_load;

    logic hazard_rA;
    logic hazard_rB;
    logic ins_valid;

    hdu_fwd_pick #(
        .ADDR_W     (AW),
        .DEPTH      (FWD_DEPTH),
        .LOAD_READY (LOAD_READY_STAGE),
        .SEL_W      (SEL_W)
    ) u_pick_rA (
        .src       (id_rA),
        .ent_valid (sb_valid),
        .ent_rd    (sb_rd),
        .ent_load  (sb_load),
        .sel       (fwd_sel_rA),
        .hazard    (hazard_rA)
    );

    hdu_fwd_pick #(
        .ADDR_W     (AW),
        .DEPTH      (FWD_DEPTH),
        .LOAD_READY (LOAD_READY_STAGE),
        .SEL_W      (SEL_W)
    ) u_pick_rB (
        .src       (id_rB),
        .ent_valid (sb_valid),
        .ent_rd    (sb_rd),
        .ent_load  (sb_load),
        .sel       (fwd_sel_rB),
        .hazard    (hazard_rB)
    );

    // Stall the whole ID instruction if either operand's youngest producer is not ready.
    always_comb begin
        stall = id_valid && (hazard_rA || hazard_rB);
    end

    // Only a real, non-stalled instruction that writes a non-zero register enters EX.
    always_comb begin
        ins_valid = id_valid && !stall && id_wr_en && (id_rd != '0);
    end

    // Advance the scoreboard one stage per unfrozen cycle; the oldest entry retires
    // because the register file write-through covers it from then on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_valid <= '0;
            sb_rd    <= '0;
            sb_load  <= '0;
        end else if (!hold) begin
            for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
                sb_valid[k]        <= sb_valid[k-1];
                sb_rd[k*AW +: AW]  <= sb_rd[(k-1)*AW +: AW];
                sb_load[k]         <= sb_load[k-1];
            end
            sb_valid[STG_EX-1]           <= ins_valid;
            sb_rd[(STG_EX-1)*AW +: AW]   <= id_rd;
            sb_load[STG_EX-1]            <= id_is_load;
        end
    end

    // Count stall cycles that actually take effect, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && !hold && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule : hdu_scoreboard

// File: tb/tb_hdu_scoreboard.sv
// Scoreboard bench for hdu_scoreboard: default build and a LOAD_READY_STAGE=3 / CNT_WIDTH=2 build.
// Latency: expected outputs are pushed when inputs are driven, popped on the following negedge.
// Backpressure: n/a.
module tb_hdu_scoreboard;
    import hdu_scoreboard_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rA = '0;
    logic [4:0] id_rB = '0;
    logic       id_wr_en = 1'b0;
    logic [4:0] id_rd = '0;
    logic       id_is_load = 1'b0;
    logic       hold = 1'b0;

    logic [1:0]  sel_a0, sel_b0, sel_a1, sel_b1;
    logic        stall0, stall1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    always #5 clk = ~clk;

    hdu_scoreboard dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rA(id_rA), .id_rB(id_rB),
        .id_wr_en(id_wr_en), .id_rd(id_rd), .id_is_load(id_is_load), .hold(hold),
        .fwd_sel_rA(sel_a0), .fwd_sel_rB(sel_b0), .stall(stall0), .stall_count(cnt0)
    );

    hdu_scoreboard #(.LOAD_READY_STAGE(3), .CNT_WIDTH(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rA(id_rA), .id_rB(id_rB),
        .id_wr_en(id_wr_en), .id_rd(id_rd), .id_is_load(id_is_load), .hold(hold),
        .fwd_sel_rA(sel_a1), .fwd_sel_rB(sel_b1), .stall(stall1), .stall_count(cnt1)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int sa;
        int sb;
        int st;
        int cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // In-flight producers per build, index 1 = youngest (EX).
    sb_entry_t m[2][1:3];
    int        mcnt[2];
    int        lrs[2]  = '{2, 3};
    int        cmax[2] = '{65535, 3};

    int n_cmp = 0;
    int n_fail = 0;

    // Youngest producer of s (first in age order) decides both select and readiness.
    function automatic void pick(input int c, input logic [4:0] s, output int sel, output bit hz);
        sel = 0;
        hz  = 1'b0;
        if (s != 5'd0) begin
            for (int k = 1; k <= 3; k++) begin
                if (m[c][k].valid && m[c][k].rd == s) begin
                    sel = k;
                    hz  = m[c][k].is_load && (k < lrs[c]);
                    break;
                end
            end
        end
    endfunction

    function automatic void clear_model();
        for (int c = 0; c < 2; c++) begin
            for (int k = 1; k <= 3; k++) m[c][k] = '{valid: 1'b0, rd: 5'd0, is_load: 1'b0};
            mcnt[c] = 0;
        end
    endfunction

    // Drive one ID cycle, record expectations, then advance the model across the edge.
    task automatic step(input bit v, input logic [4:0] a, input logic [4:0] b, input bit we,
                        input logic [4:0] d, input bit ld, input bit h, input bit r);
        exp_t e[2];
        bit   st[2];
        rst_n = r; id_valid = v; id_rA = a; id_rB = b;
        id_wr_en = we; id_rd = d; id_is_load = ld; hold = h;
        if (!r) clear_model();
        for (int c = 0; c < 2; c++) begin
            int sa, sb;
            bit ha, hb;
            pick(c, a, sa, ha);
            pick(c, b, sb, hb);
            st[c] = v && (ha || hb);
            e[c]  = '{sa: sa, sb: sb, st: int'(st[c]), cnt: mcnt[c]};
        end
        q0.push_back(e[0]);
        q1.push_back(e[1]);
        @(posedge clk);
        if (r && !h) begin
            for (int c = 0; c < 2; c++) begin
                m[c][3] = m[c][2];
                m[c][2] = m[c][1];
                m[c][1] = '{valid: v && !st[c] && we && (d != 5'd0), rd: d, is_load: ld};
                if (st[c] && mcnt[c] < cmax[c]) mcnt[c]++;
            end
        end
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (q0.size() > 0 && q1.size() > 0) begin
            exp_t e0, e1;
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            check("d0_sel_rA", int'(sel_a0), e0.sa);
            check("d0_sel_rB", int'(sel_b0), e0.sb);
            check("d0_stall",  int'(stall0), e0.st);
            check("d0_count",  int'(cnt0),   e0.cnt);
            check("d1_sel_rA", int'(sel_a1), e1.sa);
            check("d1_sel_rB", int'(sel_b1), e1.sb);
            check("d1_stall",  int'(stall1), e1.st);
            check("d1_count",  int'(cnt1),   e1.cnt);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        clear_model();
        @(posedge clk);
        #1;
        // reset state
        step(1, 5'd3, 5'd3, 1, 5'd3, 0, 0, 0);
        step(1, 5'd3, 5'd3, 1, 5'd3, 0, 0, 0);
        // 1: ALU forward from EX, then from MEM
        step(1, 5'd0, 5'd0, 1, 5'd3, 0, 0, 1);
        step(1, 5'd3, 5'd0, 1, 5'd9, 0, 0, 1);
        step(1, 5'd3, 5'd0, 0, 5'd0, 0, 0, 1);
        // 2: load-use
        step(1, 5'd0, 5'd0, 1, 5'd5, 1, 0, 1);
        repeat (3) step(1, 5'd0, 5'd5, 1, 5'd6, 0, 0, 1);
        // 3: youngest producer wins
        step(1, 5'd0, 5'd0, 1, 5'd4, 0, 0, 1);
        step(1, 5'd0, 5'd0, 1, 5'd4, 0, 0, 1);
        step(1, 5'd4, 5'd4, 0, 5'd0, 0, 0, 1);
        // 4: r0 never forwards; load-use under hold
        step(1, 5'd0, 5'd0, 1, 5'd0, 0, 0, 1);
        step(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1);
        step(1, 5'd0, 5'd0, 1, 5'd7, 1, 0, 1);
        repeat (3) step(1, 5'd7, 5'd1, 0, 5'd0, 0, 1, 1);
        repeat (3) step(1, 5'd7, 5'd1, 0, 5'd0, 0, 0, 1);
        // self-reference is not a hazard; invalid ID never stalls
        step(1, 5'd8, 5'd8, 1, 5'd8, 1, 0, 1);
        step(0, 5'd8, 5'd0, 1, 5'd2, 0, 0, 1);
        // 5: repeated load-use stalls to saturate the narrow counter
        for (int i = 0; i < 5; i++) begin
            step(1, 5'd0, 5'd0, 1, 5'd10, 1, 0, 1);
            repeat (3) step(1, 5'd10, 5'd0, 0, 5'd0, 0, 0, 1);
        end
        // 6: asynchronous reset with a full scoreboard
        step(1, 5'd0, 5'd0, 1, 5'd1, 0, 0, 1);
        step(1, 5'd0, 5'd0, 1, 5'd2, 1, 0, 1);
        step(1, 5'd0, 5'd0, 1, 5'd3, 0, 0, 1);
        step(1, 5'd3, 5'd2, 0, 5'd0, 0, 0, 0);
        step(1, 5'd1, 5'd3, 0, 5'd0, 0, 0, 1);
        // randomized traffic over a small register window to provoke collisions
        for (int i = 0; i < 400; i++) begin
            bit r;
            r = ($urandom_range(0, 99) != 0);
            step($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), $urandom_range(0, 9) < 4,
                 $urandom_range(0, 9) == 0, r);
        end
        @(negedge clk);
        #1;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q0.size() + q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard bound on run time in case the stimulus process ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule : tb_hdu_scoreboard
